apb_status_regs: RTL

- APB completer register block for the requester port of the GTY APB bridge.
- Answers remote register accesses arriving over the SFP link: ID, scratch, live/sticky link-status bits, a 64-bit uptime counter and a GPIO output register.
- Single APB clock domain; status inputs from other domains are synchronized inside the block.

---
 rtl/apb_status_regs.sv | 139 +++++++++++++
 1 files changed

// File: rtl/apb_status_regs.sv
// APB completer for the GTY bridge requester port: ID, scratch, synchronized
// status with sticky edge capture, 64-bit uptime with hi shadow, and GPIO.
module apb_status_regs #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter logic [31:0] ID_VALUE     = 32'h4B55_5001,
  parameter int unsigned STATUS_WIDTH = 8,
  parameter int unsigned GPIO_WIDTH   = 8
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [31:0]             pwdata,
  input  logic [3:0]              pstrb,
  output logic                    pready,
  output logic [31:0]             prdata,
  output logic                    pslverr,
  input  logic [STATUS_WIDTH-1:0] status_in,
  output logic [GPIO_WIDTH-1:0]   gpio_out
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [31:0]             r_scratch;
  logic [GPIO_WIDTH-1:0]   r_gpio;
  logic [STATUS_WIDTH-1:0] r_sync1;
  logic [STATUS_WIDTH-1:0] r_sync2;
  logic [STATUS_WIDTH-1:0] r_sync3;
  logic [STATUS_WIDTH-1:0] r_sticky;
  logic [63:0]             r_uptime;
  logic [31:0]             r_hi_shadow;

  logic [IDX_W-1:0]        w_idx;
  logic                    w_commit;
  logic                    w_err;
  logic [31:0]             w_rdata;
  logic                    w_wr_ok;
  logic                    w_rd_lo;
  logic [31:0]             w_scratch_wr;
  logic [GPIO_WIDTH-1:0]   w_gpio_wr;
  logic [STATUS_WIDTH-1:0] w_sticky_clr;
  logic [STATUS_WIDTH-1:0] w_rise;

  // Byte-lane merge of write data into an existing word.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] wd,
                                             input logic [3:0]  st);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (st[b]) res[8*b +: 8] = wd[8*b +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (psel && !penable) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = psel ? ST_RESP : ST_IDLE;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Decode and response data; the response is latched on the ACCESS->RESP edge.
  always_comb begin
    w_idx    = paddr[4:2];
    w_commit = (r_state == ST_ACCESS) && psel;
    w_err    = (|paddr[ADDR_WIDTH-1:5]) || (|paddr[1:0]);
    w_rdata  = '0;
    case (w_idx)
      3'd0: begin w_rdata = ID_VALUE;              w_err = w_err || pwrite; end
      3'd1:       w_rdata = r_scratch;
      3'd2: begin w_rdata = 32'(r_sync2);          w_err = w_err || pwrite; end
      3'd3:       w_rdata = 32'(r_sticky);
      3'd4: begin w_rdata = r_uptime[31:0];        w_err = w_err || pwrite; end
      3'd5: begin w_rdata = r_hi_shadow;           w_err = w_err || pwrite; end
      3'd6:       w_rdata = 32'(r_gpio);
      default:    w_err   = 1'b1;
    endcase
    if (w_err) w_rdata = '0;
    w_wr_ok      = w_commit && pwrite && !w_err;
    w_rd_lo      = w_commit && !pwrite && !w_err && (w_idx == 3'd4);
    w_scratch_wr = strb_merge(r_scratch, pwdata, pstrb);
    w_gpio_wr    = GPIO_WIDTH'(strb_merge(32'(r_gpio), pwdata, pstrb));
    w_sticky_clr = '0;
    if (w_wr_ok && (w_idx == 3'd3)) w_sticky_clr = STATUS_WIDTH'(strb_merge(32'd0, pwdata, pstrb));
    w_rise       = r_sync2 & ~r_sync3;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_scratch   <= '0;
      r_gpio      <= '0;
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_sync3     <= '0;
      r_sticky    <= '0;
      r_uptime    <= '0;
      r_hi_shadow <= '0;
      pready      <= 1'b0;
      prdata      <= '0;
      pslverr     <= 1'b0;
    end else begin
      r_sync1  <= status_in;
      r_sync2  <= r_sync1;
      r_sync3  <= r_sync2;
      r_uptime <= r_uptime + 64'd1;
      // A new rising edge wins over a simultaneous W1C of the same bit.
      r_sticky <= (r_sticky & ~w_sticky_clr) | w_rise;
      if (w_wr_ok && (w_idx == 3'd1)) r_scratch <= w_scratch_wr;
      if (w_wr_ok && (w_idx == 3'd6)) r_gpio <= w_gpio_wr;
      if (w_rd_lo) r_hi_shadow <= r_uptime[63:32];
      pready  <= w_commit;
      prdata  <= w_commit ? w_rdata : 32'd0;
      pslverr <= w_commit && w_err;
    end
  end

  assign gpio_out = r_gpio;

endmodule
